// File: rtl/sprite_motion_ctrl_pkg.sv
// Shared types and constants for the sprite motion pipeline.
package sprite_pkg;

  localparam int unsigned FIXED_POINT_SHIFT = 6;
  localparam int unsigned SCREEN_W          = 640;
  localparam int unsigned SCREEN_H          = 480;

  localparam int unsigned POS_W   = 18;
  localparam int unsigned SPEED_W = 12;
  localparam int unsigned COORD_W = 11;
  localparam int unsigned EDGE_W  = 4;

  localparam int unsigned EDGE_LEFT   = 3;
  localparam int unsigned EDGE_TOP    = 2;
  localparam int unsigned EDGE_RIGHT  = 1;
  localparam int unsigned EDGE_BOTTOM = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SPEED = 2'd1,
    ST_POS   = 2'd2
  } motion_state_e;

  // Reverse a speed only when it points into an edge that was hit.
  function automatic logic signed [SPEED_W-1:0] bounce(
    input logic signed [SPEED_W-1:0] spd,
    input logic                      neg_edge_hit,
    input logic                      pos_edge_hit
  );
    if ((neg_edge_hit && (spd < 0)) || (pos_edge_hit && (spd > 0))) begin
      return -spd;
    end
    return spd;
  endfunction

endpackage

// File: rtl/sprite_motion_ctrl_edge_detect_rise.sv
// Single-bit rising-edge detector: rise_c is high for the cycle din goes 0->1.
module edge_detect_rise (
  input  logic clk,
  input  logic resetN,
  input  logic din,
  output logic rise_c
);

  logic din_q;
  logic din_d;

  always_comb begin
    din_d = din;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      din_q <= 1'b0;
    end else begin
      din_q <= din_d;
    end
  end

  assign rise_c = din & ~din_q;

endmodule

// File: rtl/sprite_motion_ctrl.sv
// Per-frame sprite position update with gravity, jump, X toggle and edge bounce.
// Define SPRITE_MOTION_WRAP_EN to wrap at the screen border instead of clamp-and-bounce.
module sprite_motion_ctrl
  import sprite_pkg::*;
#(
  parameter int INITIAL_X       = 280,
  parameter int INITIAL_Y       = 185,
  parameter int INITIAL_X_SPEED = 40,
  parameter int INITIAL_Y_SPEED = 20,
  parameter int Y_ACCEL         = 1,
  parameter int MAX_Y_SPEED     = 230,
  parameter int JUMP_SPEED      = 200
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               collision,
  input  logic [EDGE_W-1:0]  HitEdgeCode,
  input  logic               toggleX,
  input  logic               jump,
  output logic [COORD_W-1:0] topLeftX,
  output logic [COORD_W-1:0] topLeftY
);

  localparam logic signed [POS_W-1:0]   X_RST  = POS_W'(INITIAL_X <<< FIXED_POINT_SHIFT);
  localparam logic signed [POS_W-1:0]   Y_RST  = POS_W'(INITIAL_Y <<< FIXED_POINT_SHIFT);
  localparam logic signed [SPEED_W-1:0] VX_RST = SPEED_W'(INITIAL_X_SPEED);
  localparam logic signed [SPEED_W-1:0] VY_RST = SPEED_W'(INITIAL_Y_SPEED);
  localparam logic signed [SPEED_W-1:0] ACCEL  = SPEED_W'(Y_ACCEL);
  localparam logic signed [SPEED_W-1:0] MAX_VY = SPEED_W'(MAX_Y_SPEED);
  localparam logic signed [SPEED_W-1:0] JUMP_V = SPEED_W'(-JUMP_SPEED);
  localparam logic [COORD_W-1:0]        X_OUT_RST = COORD_W'(INITIAL_X);
  localparam logic [COORD_W-1:0]        Y_OUT_RST = COORD_W'(INITIAL_Y);
`ifdef SPRITE_MOTION_WRAP_EN
  localparam logic signed [POS_W-1:0]   X_SPAN = POS_W'(SCREEN_W << FIXED_POINT_SHIFT);
  localparam logic signed [POS_W-1:0]   Y_SPAN = POS_W'(SCREEN_H << FIXED_POINT_SHIFT);
`else
  localparam logic signed [POS_W-1:0]   X_MAX  = POS_W'((SCREEN_W - 1) << FIXED_POINT_SHIFT);
  localparam logic signed [POS_W-1:0]   Y_MAX  = POS_W'((SCREEN_H - 1) << FIXED_POINT_SHIFT);
`endif

  motion_state_e state_q, state_d;

  logic signed [POS_W-1:0]   x_pos_q, x_pos_d;
  logic signed [POS_W-1:0]   y_pos_q, y_pos_d;
  logic signed [SPEED_W-1:0] x_speed_q, x_speed_d;
  logic signed [SPEED_W-1:0] y_speed_q, y_speed_d;
  logic [EDGE_W-1:0]         hit_q, hit_d;
  logic                      toggle_req_q, toggle_req_d;
  logic [COORD_W-1:0]        top_left_x_q, top_left_x_d;
  logic [COORD_W-1:0]        top_left_y_q, top_left_y_d;

  logic                      toggle_rise_c;
  logic [EDGE_W-1:0]         hit_all_c;
  logic                      toggle_all_c;
  logic signed [SPEED_W-1:0] x_speed_bnc_c;
  logic signed [SPEED_W-1:0] x_speed_new_c;
  logic signed [SPEED_W-1:0] y_speed_bnc_c;
  logic signed [SPEED_W:0]   y_speed_grav_c;
  logic signed [SPEED_W-1:0] y_speed_new_c;
  logic signed [POS_W-1:0]   x_pos_sum_c;
  logic signed [POS_W-1:0]   y_pos_sum_c;

  edge_detect_rise u_toggle_rise (
    .clk    (clk),
    .resetN (resetN),
    .din    (toggleX),
    .rise_c (toggle_rise_c)
  );

  // Hits and toggles arriving in the SPEED cycle still count for this frame.
  assign hit_all_c    = hit_q | (collision ? HitEdgeCode : EDGE_W'(0));
  assign toggle_all_c = toggle_req_q | toggle_rise_c;

  // Speed pipeline: bounce, then toggle, then jump/gravity with saturation.
  assign x_speed_bnc_c  = bounce(x_speed_q, hit_all_c[EDGE_LEFT], hit_all_c[EDGE_RIGHT]);
  assign x_speed_new_c  = toggle_all_c ? -x_speed_bnc_c : x_speed_bnc_c;
  assign y_speed_bnc_c  = bounce(y_speed_q, hit_all_c[EDGE_TOP], hit_all_c[EDGE_BOTTOM]);
  assign y_speed_grav_c = (SPEED_W+1)'(y_speed_bnc_c) + (SPEED_W+1)'(ACCEL);
  assign y_speed_new_c  = jump ? JUMP_V :
                          (y_speed_grav_c > (SPEED_W+1)'(MAX_VY)) ? MAX_VY :
                          SPEED_W'(y_speed_grav_c);

  assign x_pos_sum_c = x_pos_q + POS_W'(x_speed_q);
  assign y_pos_sum_c = y_pos_q + POS_W'(y_speed_q);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (startOfFrame) state_d = ST_SPEED;
      ST_SPEED: state_d = ST_POS;
      ST_POS:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    x_pos_d      = x_pos_q;
    y_pos_d      = y_pos_q;
    x_speed_d    = x_speed_q;
    y_speed_d    = y_speed_q;
    hit_d        = hit_all_c;
    toggle_req_d = toggle_all_c;
    top_left_x_d = top_left_x_q;
    top_left_y_d = top_left_y_q;
    case (state_q)
      ST_SPEED: begin
        x_speed_d    = x_speed_new_c;
        y_speed_d    = y_speed_new_c;
        hit_d        = '0;
        toggle_req_d = 1'b0;
      end
      ST_POS: begin
        x_pos_d = x_pos_sum_c;
        y_pos_d = y_pos_sum_c;
`ifdef SPRITE_MOTION_WRAP_EN
        if (x_pos_sum_c < 0) begin
          x_pos_d = x_pos_sum_c + X_SPAN;
        end else if (x_pos_sum_c >= X_SPAN) begin
          x_pos_d = x_pos_sum_c - X_SPAN;
        end
        if (y_pos_sum_c < 0) begin
          y_pos_d = y_pos_sum_c + Y_SPAN;
        end else if (y_pos_sum_c >= Y_SPAN) begin
          y_pos_d = y_pos_sum_c - Y_SPAN;
        end
`else
        if (x_pos_sum_c < 0) begin
          x_pos_d   = '0;
          x_speed_d = -x_speed_q;
        end else if (x_pos_sum_c > X_MAX) begin
          x_pos_d   = X_MAX;
          x_speed_d = -x_speed_q;
        end
        if (y_pos_sum_c < 0) begin
          y_pos_d   = '0;
          y_speed_d = -y_speed_q;
        end else if (y_pos_sum_c > Y_MAX) begin
          y_pos_d   = Y_MAX;
          y_speed_d = -y_speed_q;
        end
`endif
        top_left_x_d = COORD_W'(x_pos_d >>> FIXED_POINT_SHIFT);
        top_left_y_d = COORD_W'(y_pos_d >>> FIXED_POINT_SHIFT);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      x_pos_q      <= X_RST;
      y_pos_q      <= Y_RST;
      x_speed_q    <= VX_RST;
      y_speed_q    <= VY_RST;
      hit_q        <= '0;
      toggle_req_q <= 1'b0;
      top_left_x_q <= X_OUT_RST;
      top_left_y_q <= Y_OUT_RST;
    end else begin
      x_pos_q      <= x_pos_d;
      y_pos_q      <= y_pos_d;
      x_speed_q    <= x_speed_d;
      y_speed_q    <= y_speed_d;
      hit_q        <= hit_d;
      toggle_req_q <= toggle_req_d;
      top_left_x_q <= top_left_x_d;
      top_left_y_q <= top_left_y_d;
    end
  end

  assign topLeftX = top_left_x_q;
  assign topLeftY = top_left_y_q;

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Scoreboard bench for sprite_motion_ctrl: stimulus queues expected frame results,
// a monitor pops and compares two cycles after each accepted startOfFrame.
module tb_sprite_motion_ctrl;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic        startOfFrame = 1'b0;
  logic        collision = 1'b0;
  logic [3:0]  HitEdgeCode = 4'h0;
  logic        toggleX = 1'b0;
  logic        jump = 1'b0;
  logic [10:0] topLeftX;
  logic [10:0] topLeftY;

  always #5 clk = ~clk;

  sprite_motion_ctrl dut (
    .clk          (clk),
    .resetN       (resetN),
    .startOfFrame (startOfFrame),
    .collision    (collision),
    .HitEdgeCode  (HitEdgeCode),
    .toggleX      (toggleX),
    .jump         (jump),
    .topLeftX     (topLeftX),
    .topLeftY     (topLeftY)
  );

  typedef struct {
    int x;
    int y;
    int xp;
    int yp;
    int vx;
    int vy;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  exp_t stim_e;

  int checks = 0;
  int errors = 0;
  int aborts_req = 0;
  int aborts_done = 0;

  // Reference model state
  int       mx, my, mvx, mvy;
  bit [3:0] mhit;
  bit       mtog;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic m_reset();
    mx = 280 * 64; my = 185 * 64; mvx = 40; mvy = 20; mhit = 4'h0; mtog = 1'b0;
  endtask

  task automatic m_frame(input bit j);
    if ((mhit[3] && mvx < 0) || (mhit[1] && mvx > 0)) mvx = -mvx;
    if ((mhit[2] && mvy < 0) || (mhit[0] && mvy > 0)) mvy = -mvy;
    if (mtog) mvx = -mvx;
    if (j) mvy = -200;
    else begin
      mvy = mvy + 1;
      if (mvy > 230) mvy = 230;
    end
    mhit = 4'h0; mtog = 1'b0;
    mx = mx + mvx; my = my + mvy;
`ifdef SPRITE_MOTION_WRAP_EN
    if (mx < 0) mx = mx + 640 * 64; else if (mx >= 640 * 64) mx = mx - 640 * 64;
    if (my < 0) my = my + 480 * 64; else if (my >= 480 * 64) my = my - 480 * 64;
`else
    if (mx < 0) begin mx = 0; mvx = -mvx; end
    else if (mx > 639 * 64) begin mx = 639 * 64; mvx = -mvx; end
    if (my < 0) begin my = 0; mvy = -mvy; end
    else if (my > 479 * 64) begin my = 479 * 64; mvy = -mvy; end
`endif
    stim_e.x = mx / 64; stim_e.y = my / 64; stim_e.xp = mx; stim_e.yp = my;
    stim_e.vx = mvx; stim_e.vy = mvy;
  endtask

  // when: 0 no hit, 1 hit while idle before the frame, 2 hit during the SPEED cycle
  task automatic run_frame(input bit j, input logic [3:0] code, input int when, input bit tog,
                           input bit use_hand, input int hx, input int hy, input int hxp,
                           input int hyp, input int hvx, input int hvy);
    if (tog) begin
      @(negedge clk) toggleX = 1'b1;
      @(negedge clk) toggleX = 1'b0;
      mtog = 1'b1;
    end
    if (when == 1) begin
      @(negedge clk) begin collision = 1'b1; HitEdgeCode = code; end
      @(negedge clk) begin collision = 1'b0; HitEdgeCode = 4'h0; end
    end
    if (when != 0) mhit = mhit | code;
    @(negedge clk);
    m_frame(j);
    if (use_hand) begin
      stim_e.x = hx; stim_e.y = hy; stim_e.xp = hxp; stim_e.yp = hyp;
      stim_e.vx = hvx; stim_e.vy = hvy;
    end
    sb.push_back(stim_e);
    startOfFrame = 1'b1; jump = j;
    @(negedge clk);
    startOfFrame = 1'b0;
    if (when == 2) begin collision = 1'b1; HitEdgeCode = code; end
    @(negedge clk);
    collision = 1'b0; HitEdgeCode = 4'h0; jump = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic frame(input bit j, input logic [3:0] code, input int when, input bit tog);
    run_frame(j, code, when, tog, 1'b0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_x"}, int'(topLeftX), 280);
    chk({tag, "_y"}, int'(topLeftY), 185);
    chk({tag, "_xpos"}, int'(dut.x_pos_q), 17920);
    chk({tag, "_ypos"}, int'(dut.y_pos_q), 11840);
    chk({tag, "_vx"}, int'(dut.x_speed_q), 40);
    chk({tag, "_vy"}, int'(dut.y_speed_q), 20);
  endtask

  // Monitor: outputs are final two cycles after an accepted startOfFrame.
  initial begin
    forever begin
      @(posedge clk);
      if (resetN && startOfFrame) begin
        repeat (2) @(posedge clk);
        #1;
        if (aborts_req != aborts_done) begin
          aborts_done++;
        end else if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_underflow: got output with no expected entry");
        end else begin
          mon_e = sb.pop_front();
          chk("topLeftX", int'(topLeftX), mon_e.x);
          chk("topLeftY", int'(topLeftY), mon_e.y);
          chk("xpos", int'(dut.x_pos_q), mon_e.xp);
          chk("ypos", int'(dut.y_pos_q), mon_e.yp);
          chk("xspeed", int'(dut.x_speed_q), mon_e.vx);
          chk("yspeed", int'(dut.y_speed_q), mon_e.vy);
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    m_reset();
    repeat (3) @(negedge clk);
    chk_reset_state("rst");
    resetN = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset_state("rst_idle");

    // Free motion, then Right hits with positive and already-negative X speed
    run_frame(1'b0, 4'h0, 0, 1'b0, 1'b1, 280, 185, 17960, 11861, 40, 21);
    run_frame(1'b0, 4'h0, 0, 1'b0, 1'b1, 281, 185, 18000, 11883, 40, 22);
    run_frame(1'b0, 4'h2, 1, 1'b0, 1'b1, 280, 186, 17960, 11906, -40, 23);
    run_frame(1'b0, 4'h2, 1, 1'b0, 1'b1, 280, 186, 17920, 11930, -40, 24);

    // Bottom hit during the SPEED cycle, then coast to Yspeed=-10 and hit Left+Top corner
    frame(1'b0, 4'h1, 2, 1'b0);
    for (int i = 0; i < 13; i++) frame(1'b0, 4'h0, 0, 1'b0);
    frame(1'b0, 4'hC, 1, 1'b0);
    // Left and Right together reverse X once
    frame(1'b0, 4'hA, 1, 1'b0);

    frame(1'b0, 4'h0, 0, 1'b1);
    frame(1'b0, 4'h0, 0, 1'b1);

    // Jump up to the top edge, then fall long enough to saturate
    for (int i = 0; i < 160; i++) frame(1'b1, 4'h0, 0, 1'b0);
    for (int i = 0; i < 400; i++) frame(1'b0, 4'h0, 0, 1'b0);

    // Back-to-back startOfFrame: second pulse lands in SPEED and is ignored
    @(negedge clk);
    m_frame(1'b0);
    sb.push_back(stim_e);
    startOfFrame = 1'b1;
    @(negedge clk);
    @(negedge clk) startOfFrame = 1'b0;
    repeat (3) @(negedge clk);

    // Long run drives X into the screen edges
    for (int i = 0; i < 700; i++) frame(1'b0, 4'h0, 0, 1'b0);

    // Reset asserted while in SPEED
    @(negedge clk) startOfFrame = 1'b1;
    @(negedge clk);
    startOfFrame = 1'b0;
    aborts_req++;
    resetN = 1'b0;
    #1;
    chk_reset_state("midrst");
    m_reset();
    repeat (2) @(negedge clk);
    resetN = 1'b1;
    repeat (2) @(negedge clk);
    run_frame(1'b0, 4'h0, 0, 1'b0, 1'b1, 280, 185, 17960, 11861, 40, 21);
    run_frame(1'b0, 4'h0, 0, 1'b0, 1'b1, 281, 185, 18000, 11883, 40, 22);

    repeat (20) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sprite_motion_ctrl.md
Name: sprite_motion_ctrl

Overview:
- Upstream stage of the sprite pipeline: computes the sprite's top-left screen position once per video frame.
- The position feeds the rectangle/offset stage, which in turn drives the sprite bitmap.
- Consumes the bitmap's HitEdgeCode together with a collision pulse from the collision detector, and bounces the sprite off the hit edge.
- Applies gravity, a keyboard jump and a keyboard X-direction toggle; all motion is fixed-point.

Parameters:
- INITIAL_X, 280, reset top-left X in pixels
- INITIAL_Y, 185, reset top-left Y in pixels
- INITIAL_X_SPEED, 40, reset X speed, fixed-point units per frame
- INITIAL_Y_SPEED, 20, reset Y speed, fixed-point units per frame
- Y_ACCEL, 1, gravity added to Y speed each frame
- MAX_Y_SPEED, 230, Y speed saturation magnitude
- JUMP_SPEED, 200, Y speed magnitude applied on jump
- FIXED_POINT_SHIFT, 6, fractional bits (x64)
- SCREEN_W, 640 / SCREEN_H, 480, visible area in pixels

Ports:
- clk  in  1  pixel clock
- resetN  in  1  asynchronous, active-low reset
- startOfFrame  in  1  one-cycle pulse per frame
- collision  in  1  sprite overlaps an obstacle this pixel
- HitEdgeCode  in  4  {Left,Top,Right,Bottom}, valid while collision=1
- toggleX  in  1  key level; a rising edge reverses X direction
- jump  in  1  key level
- topLeftX  out  11  sprite X in pixels
- topLeftY  out  11  sprite Y in pixels

Behaviour:
- Reset: Xpos=INITIAL_X<<6, Ypos=INITIAL_Y<<6, Xspeed=INITIAL_X_SPEED, Yspeed=INITIAL_Y_SPEED; hit flags, edge register and state cleared.
- Reset outputs: topLeftX=INITIAL_X, topLeftY=INITIAL_Y.
- Internal widths: Xpos/Ypos signed 18-bit; speeds signed 12-bit.
- Outputs are registered: topLeft = pos >>> FIXED_POINT_SHIFT, truncated to 11 bits.
- Hit collection, in any state: each cycle with collision=1 ORs HitEdgeCode into a sticky 4-bit hitReg.
- toggleX rising edge is detected with a 1-cycle delay register and sets a sticky toggleReq.
- FSM states: IDLE -> SPEED -> POS -> IDLE.
- IDLE: on startOfFrame go to SPEED. A startOfFrame pulse while not in IDLE is ignored.
- SPEED, with update order fixed:
  1. Bounce using hitReg|current-cycle hit: Left && Xspeed<0 or Right && Xspeed>0 -> negate Xspeed; Top && Yspeed<0 or Bottom && Yspeed>0 -> negate Yspeed.
  2. If toggleReq, negate Xspeed, after the bounce.
  3. If jump=1, Yspeed=-JUMP_SPEED; otherwise Yspeed+=Y_ACCEL, saturating at +MAX_Y_SPEED.
  4. Clear hitReg and toggleReq.
- Hits arriving in the SPEED cycle itself belong to this frame.
- POS: Xpos+=Xspeed, Ypos+=Yspeed, then boundary handling. Outputs update at the end of POS.
- Latency: outputs change 2 cycles after the startOfFrame pulse and hold stable for the rest of the frame.
- Boundary (default clamp): X is clamped to [0,(SCREEN_W-1)<<6] and Y to [0,(SCREEN_H-1)<<6]. When clamped, the corresponding speed is negated.
- Simultaneous Left and Right hits: X speed is negated at most once; the same rule applies to Top and Bottom.
- Reset mid-frame: immediate return to reset values.

Optional Feature:
- Macro: SPRITE_MOTION_WRAP_EN.
- Defined: boundary wraps instead of clamping. pos<0 -> pos+=SCREEN<<6; pos>=SCREEN<<6 -> pos-=SCREEN<<6. Speed is unchanged.
- Undefined: clamp-and-bounce as described in Behaviour.

Decomposition:
- Shared package sprite_pkg:
  - edge bit indices EDGE_LEFT=3, EDGE_TOP=2, EDGE_RIGHT=1, EDGE_BOTTOM=0
  - FIXED_POINT_SHIFT, SCREEN_W, SCREEN_H
  - motion state enum type
- One sub-module: edge_detect_rise (1-bit rising-edge pulse), used for toggleX.

Test Plan:
- Reset, then 2 frames with no input -> topLeftX 280, 280, 281 (Xpos 17920, 17960, 18000); Yspeed 21 then 22.
- collision=1 with HitEdgeCode=4'h2 mid-frame, Xspeed=+40 -> next frame Xspeed=-40 and Xpos drops by 40. Repeat with Xspeed already -40 -> no change.
- collision with HitEdgeCode=4'hC (Left+Top corner), Xspeed=-40, Yspeed=-10 -> Xspeed=+40, Yspeed=+10+1=11.
- jump=1 during startOfFrame -> Yspeed=-200, topLeftY falls by 3 pixels. Hold jump low for 400 frames -> Yspeed saturates at 230.
- Drive Xpos toward the right edge -> topLeftX never exceeds 639 and Xspeed flips. With SPRITE_MOTION_WRAP_EN -> topLeftX goes 639 to 0.
- Assert resetN low 1 cycle after startOfFrame (in SPEED) -> outputs 280/185 immediately; startOfFrame pulses 1 cycle apart -> second pulse ignored.
